// File: rtl/dump_pkg.sv
// dump_pkg: shared FSM state encoding and sizing constants for regfile_dump_reader
package dump_pkg;
  typedef enum logic [1:0] {IDLE, HDR, SETTLE, SEND} state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int SEL_W = 5;
endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: load latches word, then emits its BYTES_PER_WORD bytes MSB first on tx_data/tx_valid/tx_ready; last_byte marks the final byte
module word_byte_serializer import dump_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_byte
);
  logic [31:0] sh_q, sh_d;
  logic [1:0] idx_q, idx_d;
  logic valid_q, valid_d, xfer;
  always_comb begin
    last_byte = idx_q == 2'(BYTES_PER_WORD - 1);
    xfer = valid_q & tx_ready;
    sh_d = load ? word : (xfer & ~last_byte) ? {sh_q[23:0], 8'h00} : sh_q;
    idx_d = load ? 2'd0 : xfer ? idx_q + 2'd1 : idx_q;
    valid_d = load | (valid_q & ~(xfer & last_byte));
    tx_data = sh_q[31:24];
    tx_valid = valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: on start sweeps reg_sel 0..NUM_REGS-1, captures reg_val after SETTLE_CYCLES, streams each word MSB first on tx_data/tx_valid/tx_ready with busy/done; DUMP_PC_HEADER_EN prefixes the pc_in snapshot
module regfile_dump_reader import dump_pkg::*; #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [31:0]      reg_val,
  input  logic [31:0]      pc_in,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic busy_q, busy_d, done_q, done_d, load, last_byte, xfer_last, last_reg;
  logic [31:0] word;
  word_byte_serializer u_ser (
    .clk(clk),
    .reset(reset),
    .load(load),
    .word(word),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .last_byte(last_byte)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    busy_d = busy_q;
    done_d = 1'b0;
    load = 1'b0;
    word = state_q == SETTLE ? reg_val : pc_in;
    xfer_last = tx_valid & tx_ready & last_byte;
    last_reg = sel_q == SEL_W'(NUM_REGS - 1);
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        sel_d = '0;
        cnt_d = 4'(SETTLE_CYCLES);
`ifdef DUMP_PC_HEADER_EN
        load = 1'b1;
        state_d = HDR;
`else
        state_d = SETTLE;
`endif
      end
      HDR: if (xfer_last) begin
        cnt_d = 4'(SETTLE_CYCLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        load = cnt_q == 4'd1;
        state_d = load ? SEND : SETTLE;
      end
      SEND: if (xfer_last) begin
        cnt_d = 4'(SETTLE_CYCLES);
        sel_d = last_reg ? sel_q : sel_q + 1'b1;
        busy_d = ~last_reg;
        done_d = last_reg;
        state_d = last_reg ? IDLE : SETTLE;
      end
      default: ;
    endcase
    reg_sel = sel_q;
    busy = busy_q;
    done = done_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized sweeps checked against a byte-stream and latency model of the register dump reader
module tb_regfile_dump_reader;
  localparam int S = 3;
  localparam int N = 32;
`ifdef DUMP_PC_HEADER_EN
  localparam int HB = 4;
`else
  localparam int HB = 0;
`endif
  localparam int T = N * (S + 4) + HB;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, tx_ready = 1'b0;
  logic [31:0] pc_in = '0;
  logic [4:0] reg_sel, d1, d2;
  logic [31:0] reg_val;
  logic [7:0] tx_data;
  logic tx_valid, busy, done;
  logic [31:0] vals [N];
  logic [7:0] exp_q[$], got_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_n = 0, done_cyc = 0, start_cyc = 0;
  bit stall = 1'b0;
  logic [7:0] stall_data;
  regfile_dump_reader #(.SETTLE_CYCLES(S), .NUM_REGS(N)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .reg_sel(reg_sel),
    .reg_val(reg_val),
    .pc_in(pc_in),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= reg_sel;
    d2 <= d1;
  end
  assign reg_val = vals[d2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input bit st, input bit chain, input int pct, input bit rst);
    @(negedge clk);
    tx_ready = $urandom_range(99) < pct;
    #1;
    if (stall) begin
      chk("hold_valid", {31'b0, tx_valid}, 32'd1);
      chk("hold_data", {24'b0, tx_data}, {24'b0, stall_data});
    end
    stall = tx_valid && !tx_ready;
    stall_data = tx_data;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    start = st || (chain && done);
    if (start && !busy) start_cyc = cyc;
    reset = rst;
    cyc++;
  endtask
  task automatic build_exp(input int mode);
    exp_q.delete();
    got_q.delete();
    done_n = 0;
    if (mode == 0) foreach (vals[i]) vals[i] = 32'h1000_0000 + i;
    if (mode == 1) foreach (vals[i]) vals[i] = $urandom;
    if (mode == 0) pc_in = 32'h0040_0020;
    if (mode == 1) pc_in = $urandom;
`ifdef DUMP_PC_HEADER_EN
    for (int b = 3; b >= 0; b--) exp_q.push_back(pc_in[b*8 +: 8]);
`endif
    foreach (vals[i]) for (int b = 3; b >= 0; b--) exp_q.push_back(vals[i][b*8 +: 8]);
  endtask
  task automatic sweep(input string tag, input int pct, input bit already, input bit chain, input bit poke);
    bit poked = 1'b0;
    int t0;
    if (!already) tick(1'b1, 1'b0, pct, 1'b0);
    t0 = start_cyc;
    for (int i = 0; i < 4000 && done_n == 0; i++) begin
      if (poke && !poked && busy && reg_sel == 5'd5) begin
        poked = 1'b1;
        tick(1'b1, 1'b0, pct, 1'b0);
      end else tick(1'b0, chain, pct, 1'b0);
      if (i == 0) pc_in = $urandom;
    end
    chk({tag, "_done_seen"}, done_n, 1);
    if (pct == 100) chk({tag, "_latency"}, done_cyc - t0, T + 1);
    chk({tag, "_byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), i < got_q.size() ? {24'b0, got_q[i]} : 32'hxxxx_xxxx, {24'b0, exp_q[i]});
    chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
  endtask
  initial begin
    repeat (3) tick(1'b0, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("rst_reg_sel", {27'b0, reg_sel}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    build_exp(0);
    sweep("basic", 100, 1'b0, 1'b0, 1'b0);
    build_exp(1);
    sweep("bp_poke", 30, 1'b0, 1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0, 100, 1'b0);
    chk("no_extra_done", done_n, 1);
    chk("no_extra_bytes", got_q.size(), exp_q.size());
    build_exp(1);
    sweep("chain_a", 100, 1'b0, 1'b1, 1'b0);
    build_exp(2);
    sweep("chain_b", 100, 1'b1, 1'b0, 1'b0);
    build_exp(1);
    tick(1'b1, 1'b0, 100, 1'b0);
    for (int i = 0; i < 2000 && !(reg_sel == 5'd10 && tx_valid); i++) tick(1'b0, 1'b0, 100, 1'b0);
    chk("reach_sel10", {27'b0, reg_sel}, 32'd10);
    tick(1'b0, 1'b0, 100, 1'b1);
    got_q.delete();
    done_n = 0;
    tick(1'b0, 1'b0, 100, 1'b0);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_reg_sel", {27'b0, reg_sel}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    repeat (10) tick(1'b0, 1'b0, 100, 1'b0);
    chk("post_rst_bytes", got_q.size(), 0);
    chk("post_rst_done", done_n, 0);
    build_exp(1);
    sweep("after_rst", 60, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
